eth_rx_parser: RTL and testbench
================================

// Module: eth_rx_parser
// PURPOSE
//  Byte-level Ethernet receive parser between RGMII DDR capture (rxclk domain) and rx2da sample RAM.
//  Finds preamble/SFD, filters on destination MAC and EtherType, and strips the 14-byte header.
//  Latches payload byte 0 as the DAC divider and writes the remaining bytes into one half of a
//  ping-pong RAM. Checks CRC32; on a good frame it hands that half to the DAC side.
// PARAMETERS
//  ADDR_W     14                 sample RAM address width; bank = MSB, offset = ADDR_W-1 bits
//  MAC_ADDR   48'h02_00_00_00_00_01  accepted unicast destination (broadcast FF..FF also accepted)
//  ETHERTYPE  16'h88B5           accepted EtherType
// PORTS
//  rxclk      in   1       byte clock from RGMII capture; all logic on rising edge
//  reset      in   1       synchronous, active-high
//  rx_dv      in   1       byte valid (RGMII rxctl rising-edge half)
//  rx_er      in   1       receive error (rxctl XOR of both halves)
//  rx_data    in   8       received byte, LSB first on wire
//  wr_en      out  1       RAM write strobe
//  wr_addr    out  ADDR_W  RAM write address {~rd_bank, offset}
//  wr_data    out  8       RAM write data
//  rd_bank    out  1       bank holding the last good frame (DAC reads this bank)
//  frame_len  out  ADDR_W-1  sample count of last good frame (excludes div byte and FCS)
//  div        out  8       divider byte of last good frame
//  frame_ok   out  1       1-cycle pulse: good frame committed
//  frame_bad  out  1       1-cycle pulse: frame dropped (filter miss, CRC, rx_er, runt, overflow)
// BEHAVIOUR
//  Reset: all outputs 0; rd_bank=0, so first frame writes bank 1. State=WAIT_IDLE.
//  States and transitions (evaluated per rxclk):
//   WAIT_IDLE: stay until rx_dv=0 -> IDLE (never start mid-frame after reset).
//   IDLE: rx_dv&data==55 -> PRE; rx_dv&data==D5 -> HDR; rx_dv&other -> DROP.
//   PRE: 55 stay; D5 -> HDR, clear CRC (FFFFFFFF), hdr_cnt=0; other -> DROP; rx_dv=0 -> IDLE, no pulse.
//   HDR: bytes 0-5 compared to MAC_ADDR (MSB first) and FF..FF; bytes 12-13 to ETHERTYPE.
//        Miss is latched and gives DROP after byte 13. After byte 13 with no miss -> DIV.
//   DIV: byte latched into div_pend -> PAY.
//   PAY: every byte: wr_en=1, wr_data=byte, wr_addr={~rd_bank,offset}, offset++.
//        The 4 FCS bytes are also written (end of frame is unknown in advance).
//   DROP: no writes; on rx_dv=0 pulse frame_bad -> IDLE.
//  CRC32: reflected, poly EDB88320, init FFFFFFFF. Covers header through FCS.
//   Good iff register==DEBB20E3 after the last byte.
//  End of frame: rx_dv 1->0 in HDR/DIV/PAY. Next cycle exactly one of frame_ok/frame_bad pulses -> IDLE.
//   Good: state PAY, CRC good, no rx_er, offset>=4.
//   frame_ok cycle (same edge): rd_bank<=~rd_bank, frame_len<=offset-4, div<=div_pend.
//   Bad: only the pulse; rd_bank/frame_len/div unchanged. Written bytes in the inactive bank are don't-care.
//  Registered wr_*: 1 cycle after byte accepted. wr_en=0 outside PAY; wr_data/wr_addr hold last value.
//  rx_er=1 on any rx_dv cycle after SFD marks the frame bad. Writes continue; pulse at end.
//  Overflow: offset reaching 2^(ADDR_W-1) -> DROP (no wrap into other bank); frame_bad at end.
//   Max samples = 2^(ADDR_W-1)-4.
//  Runt: ends in HDR/DIV, or PAY with offset<4 -> frame_bad.
//  Back-to-back frames: rx_dv high the cycle after falling is handled from IDLE (pulse and start coexist).
//  Reset mid-frame: immediate abort, no pulse, outputs reset, WAIT_IDLE.
// TESTING
//  1) Reset, rx_dv=0 -> all outputs 0, rd_bank=0.
//  2) Good frame: 7x55,D5, MAC, EtherType 88B5, div=0x10, samples 00..63, valid FCS.
//     -> 100 writes to 0x2000.. then 4 FCS writes; frame_ok; frame_len=100, div=0x10, rd_bank=1.
//  3) Same frame with one FCS bit flipped -> frame_bad; rd_bank, frame_len, div unchanged.
//     Second good frame then writes bank 0 (wr_addr 0x0000..) and sets rd_bank=0.
//  4) Wrong dst MAC or EtherType 0800 -> no wr_en at all, frame_bad once.
//     Broadcast dst -> accepted, frame_ok.
//  5) rx_er pulse mid-payload -> frame_bad.
//     Payload of 8192 bytes (overflow) -> writes stop at offset 1FFF, frame_bad.
//  6) reset asserted mid-payload with rx_dv held -> no pulse, no writes; nothing accepted until rx_dv low;
//     next good frame -> frame_ok, writes bank 1.

Source files
------------

// File: rtl/eth_rx_parser.sv
// rtl/eth_rx_parser.sv - Ethernet receive parser: preamble/SFD, MAC/EtherType filter, CRC32, ping-pong sample writes
module eth_rx_parser #(
    parameter int          ADDR_W    = 14,
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic              rx_dv,
    input  logic              rx_er,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_bank,
    output logic [ADDR_W-2:0] frame_len,
    output logic [7:0]        div,
    output logic              frame_ok,
    output logic              frame_bad
);
    localparam int          OFF_W       = ADDR_W - 1;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PRE,
        HDR,
        DIV,
        PAY,
        DROP
    } state_t;

    state_t state, state_n;

    logic [31:0]       crc;
    logic [3:0]        hdr_cnt;
    logic              uc_miss, bc_miss, et_miss;
    logic              uc_miss_n, bc_miss_n, et_miss_n;
    logic              err;
    // One spare MSB: when set the bank is full and the next byte overflows
    logic [ADDR_W-1:0] offset;
    logic [7:0]        div_pend;
    logic [47:0]       mac_sh;

    logic hdr_start, hdr_step, crc_upd, div_load, pay_write, end_ok, end_bad;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Header compare; misses are accumulated and only acted on after byte 13
    always_comb begin
        mac_sh    = MAC_ADDR << {hdr_cnt, 3'b000};
        uc_miss_n = uc_miss;
        bc_miss_n = bc_miss;
        et_miss_n = et_miss;
        if (hdr_cnt < 4'd6) begin
            uc_miss_n = uc_miss | (rx_data != mac_sh[47:40]);
            bc_miss_n = bc_miss | (rx_data != 8'hFF);
        end
        if (hdr_cnt == 4'd12) et_miss_n = et_miss | (rx_data != ETHERTYPE[15:8]);
        if (hdr_cnt == 4'd13) et_miss_n = et_miss | (rx_data != ETHERTYPE[7:0]);
    end

    always_ff @(posedge rxclk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        hdr_start = 1'b0;
        hdr_step  = 1'b0;
        crc_upd   = 1'b0;
        div_load  = 1'b0;
        pay_write = 1'b0;
        end_ok    = 1'b0;
        end_bad   = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (!rx_dv) state_n = IDLE;
            end
            IDLE, PRE: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                end else if (rx_data == 8'h55) begin
                    state_n = PRE;
                end else if (rx_data == 8'hD5) begin
                    state_n   = HDR;
                    hdr_start = 1'b1;
                end else begin
                    state_n = DROP;
                end
            end
            HDR: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                    end_bad = 1'b1;
                end else begin
                    crc_upd  = 1'b1;
                    hdr_step = 1'b1;
                    if (hdr_cnt == 4'd13)
                        state_n = ((uc_miss_n & bc_miss_n) | et_miss_n) ? DROP : DIV;
                end
            end
            DIV: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                    end_bad = 1'b1;
                end else begin
                    crc_upd  = 1'b1;
                    div_load = 1'b1;
                    state_n  = PAY;
                end
            end
            PAY: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                    if (crc == CRC_RESIDUE && !err && offset >= ADDR_W'(4)) end_ok  = 1'b1;
                    else                                                    end_bad = 1'b1;
                end else if (offset[ADDR_W-1]) begin
                    state_n = DROP;
                end else begin
                    crc_upd   = 1'b1;
                    pay_write = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                    end_bad = 1'b1;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_bank   <= 1'b0;
            frame_len <= '0;
            div       <= '0;
            frame_ok  <= 1'b0;
            frame_bad <= 1'b0;
            crc       <= CRC_INIT;
            hdr_cnt   <= '0;
            uc_miss   <= 1'b0;
            bc_miss   <= 1'b0;
            et_miss   <= 1'b0;
            err       <= 1'b0;
            offset    <= '0;
            div_pend  <= '0;
        end else begin
            wr_en     <= pay_write;
            frame_ok  <= end_ok;
            frame_bad <= end_bad;
            if (hdr_start) begin
                crc     <= CRC_INIT;
                hdr_cnt <= '0;
                uc_miss <= 1'b0;
                bc_miss <= 1'b0;
                et_miss <= 1'b0;
                err     <= 1'b0;
                offset  <= '0;
            end else if (crc_upd) begin
                crc <= crc32_byte(crc, rx_data);
                if (rx_er) err <= 1'b1;
            end
            if (hdr_step) begin
                hdr_cnt <= hdr_cnt + 4'd1;
                uc_miss <= uc_miss_n;
                bc_miss <= bc_miss_n;
                et_miss <= et_miss_n;
            end
            if (div_load) div_pend <= rx_data;
            if (pay_write) begin
                wr_data <= rx_data;
                wr_addr <= {~rd_bank, offset[ADDR_W-2:0]};
                offset  <= offset + ADDR_W'(1);
            end
            // The four trailing FCS bytes were written as samples; drop them from the count
            if (end_ok) begin
                rd_bank   <= ~rd_bank;
                frame_len <= offset[ADDR_W-2:0] - OFF_W'(4);
                div       <= div_pend;
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_parser.sv
// tb/tb_eth_rx_parser.sv - randomized scoreboard bench for eth_rx_parser
module tb_eth_rx_parser;
    localparam int          BANK_BYTES = 8192;
    localparam logic [47:0] MAC        = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST      = 48'hFFFF_FFFF_FFFF;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        rx_dv   = 1'b0;
    logic        rx_er   = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_bank;
    logic [12:0] frame_len;
    logic [7:0]  div;
    logic        frame_ok;
    logic        frame_bad;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [13:0] addr; logic [7:0] data; } wr_t;
    typedef struct { bit ok; bit bank; logic [12:0] len; logic [7:0] div; } res_t;

    wr_t        exp_wr[$];
    res_t       exp_res[$];
    logic [7:0] frm[$];
    logic [7:0] stream[$];
    logic [7:0] s1[$];
    bit         m_bank;
    logic [12:0] m_len;
    logic [7:0] m_div;

    eth_rx_parser dut (
        .rxclk     (clk),
        .reset     (reset),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_bank   (rd_bank),
        .frame_len (frame_len),
        .div       (div),
        .frame_ok  (frame_ok),
        .frame_bad (frame_bad)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Standard Ethernet FCS over q[start +: len]
    function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int start, input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, q[start+i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] d,
                               input int n, input bit ramp);
        logic [31:0] fcs;
        frm = {};
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        frm.push_back(d);
        for (int i = 0; i < n; i++) frm.push_back(ramp ? i[7:0] : 8'($urandom));
        fcs = fcs_of(frm, 0, frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask

    task automatic make_stream(input int pre);
        stream = {};
        for (int i = 0; i < pre; i++) stream.push_back(8'h55);
        stream.push_back(8'hD5);
        foreach (frm[i]) stream.push_back(frm[i]);
    endtask

    // Predicts writes and end-of-frame outcome for the whole byte burst in 'stream'
    task automatic model_stream(input int er_idx);
        int k, b, L, n, nw;
        logic [47:0] dst;
        logic [15:0] et;
        logic [31:0] rx_fcs;
        res_t r;
        wr_t  w;
        k = 0;
        n = 0;
        b = 0;
        while (k < stream.size() && stream[k] == 8'h55) k++;
        if (k == stream.size()) return;
        r.ok = 1'b0;
        if (stream[k] == 8'hD5) begin
            b = k + 1;
            L = stream.size() - b;
            if (L >= 14) begin
                dst = '0;
                for (int i = 0; i < 6; i++) dst = {dst[39:0], stream[b+i]};
                et = {stream[b+12], stream[b+13]};
                if ((dst == MAC || dst == BCAST) && et == 16'h88B5 && L > 14) begin
                    n  = L - 15;
                    nw = (n > BANK_BYTES) ? BANK_BYTES : n;
                    for (int i = 0; i < nw; i++) begin
                        w.addr = {~m_bank, 13'(i)};
                        w.data = stream[b+15+i];
                        exp_wr.push_back(w);
                    end
                    if (n >= 4 && n <= BANK_BYTES && !(er_idx > k)) begin
                        rx_fcs = {stream[b+L-1], stream[b+L-2], stream[b+L-3], stream[b+L-4]};
                        if (fcs_of(stream, b, L - 4) == rx_fcs) r.ok = 1'b1;
                    end
                end
            end
        end
        if (r.ok) begin
            m_bank = ~m_bank;
            m_len  = 13'(n - 4);
            m_div  = stream[b+14];
        end
        r.bank = m_bank;
        r.len  = m_len;
        r.div  = m_div;
        exp_res.push_back(r);
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        rx_dv   = dv;
        rx_er   = er;
        rx_data = d;
    endtask

    task automatic send_stream(input int er_idx, input int gap);
        for (int i = 0; i < stream.size(); i++) drive(1'b1, (i == er_idx), stream[i]);
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic run_frame(input int pre, input int er_idx, input int gap);
        make_stream(pre);
        model_stream(er_idx);
        send_stream(er_idx, gap);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual_addr=%0h actual_data=%0h required=no write", wr_addr, wr_data);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", wr_addr, w.addr);
                chk("wr_data", wr_data, w.data);
            end
        end
        if (frame_ok === 1'b1 || frame_bad === 1'b1) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse_unexpected actual_ok=%0b actual_bad=%0b required=no pulse", frame_ok, frame_bad);
            end else begin
                r = exp_res.pop_front();
                chk("frame_ok", frame_ok, r.ok);
                chk("frame_bad", frame_bad, !r.ok);
                chk("rd_bank", rd_bank, r.bank);
                chk("frame_len", frame_len, r.len);
                chk("div", div, r.div);
            end
        end
    end

    initial begin
        int k, er, pre, cut, sel;
        wr_t w;
        logic [47:0] dst;
        logic [15:0] et;
        m_bank = 1'b0;
        m_len  = '0;
        m_div  = '0;

        repeat (3) @(negedge clk);
        chk("rst_outputs", {wr_en, wr_addr, wr_data, rd_bank, frame_len, div, frame_ok, frame_bad}, 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_outputs", {wr_en, wr_addr, wr_data, rd_bank, frame_len, div, frame_ok, frame_bad}, 64'h0);

        // Directed good frame: ramp samples into bank 1
        build_frame(MAC, 16'h88B5, 8'h10, 100, 1'b1);
        run_frame(7, -1, 3);
        chk("t2_rd_bank", rd_bank, 1);
        chk("t2_frame_len", frame_len, 100);
        chk("t2_div", div, 8'h10);

        // Reset mid-payload with rx_dv held high
        build_frame(MAC, 16'h88B5, 8'h22, 50, 1'b0);
        make_stream(7);
        s1 = stream;
        k = 8 + 15 + 20;
        for (int i = 0; i < 20; i++) begin
            w.addr = {~m_bank, 13'(i)};
            w.data = s1[8+15+i];
            exp_wr.push_back(w);
        end
        for (int i = 0; i < k; i++) drive(1'b1, 1'b0, s1[i]);
        for (int i = k; i < k + 4; i++) begin
            @(negedge clk);
            if (i == k + 2)
                chk("rst_mid_outputs", {wr_en, rd_bank, frame_len, div, frame_ok, frame_bad}, 64'h0);
            reset   = 1'b1;
            rx_dv   = 1'b1;
            rx_data = s1[i];
        end
        m_bank = 1'b0;
        m_len  = '0;
        m_div  = '0;
        @(negedge clk);
        reset   = 1'b0;
        rx_data = s1[k+4];
        for (int i = k + 5; i < s1.size(); i++) drive(1'b1, 1'b0, s1[i]);
        build_frame(MAC, 16'h88B5, 8'h33, 20, 1'b0);
        make_stream(7);
        for (int i = 0; i < stream.size(); i++) drive(1'b1, 1'b0, stream[i]);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        build_frame(MAC, 16'h88B5, 8'h44, 12, 1'b0);
        run_frame(7, -1, 2);
        chk("t6_rd_bank", rd_bank, 1);

        // Bad FCS leaves committed state alone, next good frame flips to bank 0
        build_frame(MAC, 16'h88B5, 8'h10, 100, 1'b1);
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h08;
        run_frame(7, -1, 2);
        build_frame(MAC, 16'h88B5, 8'h5A, 30, 1'b0);
        run_frame(7, -1, 2);
        chk("t3_rd_bank", rd_bank, 0);

        // Filter misses and broadcast
        build_frame(48'h02_00_00_00_00_02, 16'h88B5, 8'h01, 20, 1'b0);
        run_frame(7, -1, 2);
        build_frame(MAC, 16'h0800, 8'h01, 20, 1'b0);
        run_frame(7, -1, 2);
        build_frame(BCAST, 16'h88B5, 8'h77, 25, 1'b0);
        run_frame(3, -1, 1);

        // rx_er mid-payload, overflow, largest accepted frame
        build_frame(MAC, 16'h88B5, 8'h09, 40, 1'b0);
        run_frame(7, 8 + 15 + 10, 2);
        build_frame(MAC, 16'h88B5, 8'h0A, BANK_BYTES, 1'b0);
        run_frame(7, -1, 3);
        build_frame(MAC, 16'h88B5, 8'h0B, BANK_BYTES - 4, 1'b0);
        run_frame(7, -1, 3);
        chk("max_frame_len", frame_len, 13'h1FFC);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 15);
            er  = -1;
            if (sel == 0) begin
                stream = {};
                for (int i = 0; i < $urandom_range(1, 12); i++) stream.push_back(8'($urandom));
            end else if (sel == 1) begin
                stream = {};
                for (int i = 0; i < $urandom_range(1, 6); i++) stream.push_back(8'h55);
            end else begin
                k   = $urandom_range(0, 9);
                dst = (k < 6) ? MAC : (k < 8) ? BCAST : {16'($urandom), 32'($urandom)};
                et  = ($urandom_range(0, 7) == 0) ? 16'h0800 : 16'h88B5;
                build_frame(dst, et, 8'($urandom), $urandom_range(0, 40), 1'b0);
                if ($urandom_range(0, 7) == 0) begin
                    k = $urandom_range(0, frm.size() - 1);
                    frm[k] = frm[k] ^ (8'h01 << $urandom_range(0, 7));
                end
                pre = $urandom_range(0, 7);
                make_stream(pre);
                if ($urandom_range(0, 7) == 0) begin
                    cut = $urandom_range(pre + 1, stream.size());
                    while (stream.size() > cut) void'(stream.pop_back());
                end
                if ($urandom_range(0, 7) == 0) er = $urandom_range(0, stream.size() - 1);
            end
            model_stream(er);
            send_stream(er, $urandom_range(1, 3));
        end

        k = 0;
        while ((exp_wr.size() != 0 || exp_res.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
